// File: rtl/perip_wb_master.sv
// Single-outstanding Wishbone classic-cycle initiator: one core request becomes one bus
// cycle, and the ack (or an ack timeout) comes back as a response on a valid/ready channel.
module perip_wb_master #(
    parameter int WB_AD_WIDTH    = 32,
    parameter int WB_DAT_WIDTH   = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    // Both channels use the same handshake: a transfer happens on a rising edge where
    // valid and ready are both high; valid and its payload stay stable until that edge.
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [WB_AD_WIDTH-1:0]    req_addr_i,
    input  logic [WB_DAT_WIDTH-1:0]   req_wdata_i,
    input  logic [WB_DAT_WIDTH/8-1:0] req_sel_i,
    input  logic                      req_we_i,
    output logic                      resp_valid_o,
    input  logic                      resp_ready_i,
    output logic [WB_DAT_WIDTH-1:0]   resp_rdata_o,
    output logic                      resp_err_o,
    output logic                      wbm_cyc_o,
    output logic                      wbm_stb_o,
    output logic [WB_AD_WIDTH-1:0]    wbm_addr_o,
    output logic [WB_DAT_WIDTH-1:0]   wbm_wdata_o,
    output logic [WB_DAT_WIDTH/8-1:0] wbm_sel_o,
    output logic                      wbm_we_o,
    input  logic [WB_DAT_WIDTH-1:0]   wbm_rdata_i,
    input  logic                      wbm_ack_i,
    output logic [1:0]                dbg_state_o
);

    localparam int SW    = WB_DAT_WIDTH / 8;
    localparam int CW    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CW-1:0] CNT_LAST = TO_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [WB_AD_WIDTH-1:0]  addr_q, addr_d;
    logic [WB_DAT_WIDTH-1:0] wdata_q, wdata_d;
    logic [SW-1:0]           sel_q, sel_d;
    logic                    we_q, we_d;
    logic [WB_DAT_WIDTH-1:0] rdata_q, rdata_d;
    logic                    err_q, err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        sel_d   = sel_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    sel_d   = req_sel_i;
                    we_d    = req_we_i;
                    cnt_d   = '0;
                    state_d = ST_BUS;
                end
            end
            ST_BUS: begin
                // Ack is checked first so an ack on the final timeout cycle still wins.
                if (wbm_ack_i) begin
                    rdata_d = we_q ? '0 : wbm_rdata_i;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (TO_EN && (cnt_q == CNT_LAST)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else if (TO_EN) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RESP: begin
                if (resp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake and strobe outputs are pure state decode; payloads come straight from flops.
    assign req_ready_o  = (state_q == ST_IDLE);
    assign resp_valid_o = (state_q == ST_RESP);
    assign wbm_cyc_o    = (state_q == ST_BUS);
    assign wbm_stb_o    = (state_q == ST_BUS);
    assign wbm_addr_o   = addr_q;
    assign wbm_wdata_o  = wdata_q;
    assign wbm_sel_o    = sel_q;
    assign wbm_we_o     = we_q;
    assign resp_rdata_o = rdata_q;
    assign resp_err_o   = err_q;
    assign dbg_state_o  = state_q;

endmodule
